pipe_stage_skid_reg: RTL and testbench
======================================

Name: pipe_stage_skid_reg

Overview:
- Parametrised successor to the fixed 32-bit F/D stage register.
- Carries a PC/IR pair between two pipeline stages using a valid/ready handshake.
- A 2-entry skid buffer keeps upstream ready a registered signal, so the stall path is cut.
- Adds flush-to-NOP and saturating stall/flush statistics counters for the hazard unit and debug.

Parameters:
- PC_W, 32, width of PC field
- IR_W, 32, width of instruction field
- RESET_PC, 0, out_pc value whenever the stage holds no valid entry
- NOP_IR, 0, out_ir value whenever the stage holds no valid entry (bubble)
- CNT_W, 16, width of statistics counters

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept; registered (no combinational path from out_ready)
- in_pc  in  PC_W  upstream PC
- in_ir  in  IR_W  upstream instruction
- out_valid  out  1  out_pc/out_ir hold a valid entry
- out_ready  in  1  downstream accepts; 0 = stall
- out_pc  out  PC_W  registered PC
- out_ir  out  IR_W  registered instruction
- flush  in  1  discard all held entries and the incoming one
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
- flush_cnt  out  CNT_W  valid entries discarded by flush, saturating

Behaviour:
- in_fire = in_valid & in_ready & !flush.
- out_fire = out_valid & out_ready.
- Storage: main entry (drives outputs) and skid entry.
- States:
  - EMPTY: main invalid.
  - ONE: main valid, skid empty.
  - FULL: both valid.
- in_ready = (state != FULL), registered. EMPTY/ONE give 1; FULL gives 0.
- out_valid = (state != EMPTY).
- While out_valid=0: out_pc=RESET_PC, out_ir=NOP_IR. These values are loaded into the main register on entry to EMPTY, not muxed.
- EMPTY:
  - in_fire: main<=in, go to ONE.
  - otherwise hold.
- ONE:
  - in_fire & out_fire: main<=in, stay ONE.
  - in_fire & !out_fire: skid<=in, go to FULL.
  - !in_fire & out_fire: main<=bubble, go to EMPTY.
  - neither: hold.
- FULL:
  - out_fire: main<=skid, go to ONE.
  - otherwise hold. No input accepted.
- Latency: one cycle from in_fire to out_valid when empty. Throughput is one entry per cycle while out_ready=1.
- Ordering: strict FIFO; skid always older than any new input; no entry duplicated or lost except by flush.
- Flush (priority over everything except rst):
  - Next state EMPTY; main<=bubble; skid cleared.
  - The in_valid entry in the same cycle is dropped.
  - out_fire in the flush cycle still counts as consumed downstream, but is not counted in flush_cnt.
  - flush_cnt += number of valid held entries not out_fired (0, 1 or 2) + (in_valid & in_ready ? 1 : 0). Saturates at 2^CNT_W-1.
- stall_cnt increments by 1 each cycle out_valid & !out_ready. Saturates; never wraps. Counts during flush cycle if the condition holds.
- Reset (rst=1 at posedge):
  - state EMPTY; out_valid=0; in_ready=1.
  - out_pc=RESET_PC; out_ir=NOP_IR.
  - stall_cnt=0; flush_cnt=0.
  - Overrides flush and any handshake in that cycle. Applies mid-transfer with the same result.
- Widths: all datapaths are exactly PC_W/IR_W with no truncation. Counters are CNT_W unsigned.

Test Plan:
- Reset then idle → out_valid=0, out_pc=0, out_ir=0, in_ready=1, both counters 0.
- Stream PC 0x3000,0x3004,0x3008 with IR 0x11,0x22,0x33, out_ready=1 → same sequence on outputs one cycle later, in_ready stays 1.
- out_ready=0 while feeding 0x3000,0x3004,0x3008 → 0x3000 held, skid takes 0x3004, in_ready=0 next cycle, 0x3008 held upstream. Release out_ready → outputs 0x3000,0x3004,0x3008 in order; stall_cnt equals stalled cycles.
- FULL state plus flush with in_valid=1 → next cycle out_valid=0, out_ir=NOP_IR, in_ready=1, flush_cnt=2 (in_ready was 0, so the input entry is not counted).
- CNT_W=2, out_ready=0 for 6 cycles with valid entry → stall_cnt saturates at 3.
- rst asserted while FULL and flush=1 → all outputs at reset values, counters 0, no flush counted.

Source files
------------

// File: rtl/pipe_stage_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid_reg
//
// Pipeline stage register that carries a PC/IR pair between two stages with a
// valid/ready handshake. It has two entries: a main entry that drives the
// outputs and a skid entry. Because of the skid entry, in_ready can come
// straight from a flop and has no combinational path from out_ready. The
// stage can also flush to a NOP bubble. It keeps saturating stall and flush
// statistics for the hazard unit and for debug.
//
// Ports:
//   clk        clock; all state changes on posedge
//   rst        synchronous active-high reset
//   in_valid   upstream entry present
//   in_ready   stage can accept (registered)
//   in_pc      upstream PC       [PC_W]
//   in_ir      upstream IR       [IR_W]
//   out_valid  out_pc/out_ir hold a valid entry
//   out_ready  downstream accepts; 0 = stall
//   out_pc     registered PC     [PC_W]
//   out_ir     registered IR     [IR_W]
//   flush      discard held entries and the incoming one
//   stall_cnt  cycles with out_valid & !out_ready, saturating [CNT_W]
//   flush_cnt  valid entries discarded by flush, saturating   [CNT_W]
// ---------------------------------------------------------------------------
module pipe_stage_skid_reg #(
  parameter int              PC_W     = 32,
  parameter int              IR_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [IR_W-1:0] NOP_IR   = '0,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [IR_W-1:0]  in_ir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [IR_W-1:0]  out_ir,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state_reg;
  logic [PC_W-1:0]   main_pc_reg, skid_pc_reg;
  logic [IR_W-1:0]   main_ir_reg, skid_ir_reg;
  logic              in_ready_reg, out_valid_reg;
  logic [CNT_W-1:0]  stall_cnt_reg, flush_cnt_reg;

  logic              in_fire, out_fire;
  logic [2:0]        held_cnt;
  logic [2:0]        flush_add;
  logic [CNT_W+1:0]  flush_sum;
  logic [CNT_W-1:0]  flush_cnt_next, stall_cnt_next;

  assign in_fire  = in_valid & in_ready_reg & ~flush;
  assign out_fire = out_valid_reg & out_ready;

  // Statistics next-values. The flush count uses in_valid & in_ready, not
  // in_fire: in_fire is already masked by flush, so it cannot show that an
  // entry was offered and then dropped.
  always_comb begin
    held_cnt = 3'd0;
    case (state_reg)
      ONE:     held_cnt = 3'd1;
      FULL:    held_cnt = 3'd2;
      default: held_cnt = 3'd0;
    endcase
    // A held entry that leaves downstream in the flush cycle is consumed, not
    // discarded. out_fire implies held_cnt >= 1, so this cannot underflow.
    flush_add = held_cnt - {2'b00, out_fire} + {2'b00, in_valid & in_ready_reg};
    flush_sum = {2'b00, flush_cnt_reg} + {{(CNT_W-1){1'b0}}, flush_add};
    flush_cnt_next = (flush_sum > {2'b00, CNT_MAX}) ? CNT_MAX : flush_sum[CNT_W-1:0];

    stall_cnt_next = stall_cnt_reg;
    if (out_valid_reg && !out_ready && (stall_cnt_reg != CNT_MAX))
      stall_cnt_next = stall_cnt_reg + 1'b1;
  end

  // The FSM keeps in_ready/out_valid registered. Each transition also sets
  // them from the state it enters. On entry to EMPTY the bubble values are
  // loaded into the main entry, so the outputs need no mux.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= EMPTY;
      main_pc_reg   <= RESET_PC;
      main_ir_reg   <= NOP_IR;
      skid_pc_reg   <= '0;
      skid_ir_reg   <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      stall_cnt_reg <= stall_cnt_next;
      if (flush) begin
        flush_cnt_reg <= flush_cnt_next;
        state_reg     <= EMPTY;
        main_pc_reg   <= RESET_PC;
        main_ir_reg   <= NOP_IR;
        skid_pc_reg   <= '0;
        skid_ir_reg   <= '0;
        in_ready_reg  <= 1'b1;
        out_valid_reg <= 1'b0;
      end else begin
        case (state_reg)
          EMPTY: begin
            if (in_fire) begin
              main_pc_reg   <= in_pc;
              main_ir_reg   <= in_ir;
              state_reg     <= ONE;
              out_valid_reg <= 1'b1;
            end
          end
          ONE: begin
            if (in_fire && out_fire) begin
              main_pc_reg <= in_pc;
              main_ir_reg <= in_ir;
            end else if (in_fire) begin
              // Downstream stalled: park the newer entry behind main.
              skid_pc_reg  <= in_pc;
              skid_ir_reg  <= in_ir;
              state_reg    <= FULL;
              in_ready_reg <= 1'b0;
            end else if (out_fire) begin
              main_pc_reg   <= RESET_PC;
              main_ir_reg   <= NOP_IR;
              state_reg     <= EMPTY;
              out_valid_reg <= 1'b0;
            end
          end
          FULL: begin
            // in_ready is low here, so the only possible move is a drain.
            if (out_fire) begin
              main_pc_reg  <= skid_pc_reg;
              main_ir_reg  <= skid_ir_reg;
              state_reg    <= ONE;
              in_ready_reg <= 1'b1;
            end
          end
          default: begin
            state_reg     <= EMPTY;
            main_pc_reg   <= RESET_PC;
            main_ir_reg   <= NOP_IR;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_pc    = main_pc_reg;
  assign out_ir    = main_ir_reg;
  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid_reg
//
// Directed testbench for pipe_stage_skid_reg. It drives two instances with
// the same inputs:
//   dut  - default parameters (RESET_PC = 0, NOP_IR = 0, CNT_W = 16)
//   dut2 - nonzero bubble values and CNT_W = 2, for the bubble and
//          saturation cases
// Inputs change 1 ns after posedge. Outputs are checked 1 ns after the next
// posedge.
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid_reg;

  localparam logic [31:0] D2_RESET_PC = 32'hFFFF_0000;
  localparam logic [31:0] D2_NOP_IR   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, flush;
  logic [31:0] in_pc, in_ir;
  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_ir;
  logic [15:0] stall_cnt, flush_cnt;
  logic        in_ready2, out_valid2;
  logic [31:0] out_pc2, out_ir2;
  logic [1:0]  stall_cnt2, flush_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_stage_skid_reg dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_ir(in_ir), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_ir(out_ir), .flush(flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_stage_skid_reg #(
    .RESET_PC(D2_RESET_PC), .NOP_IR(D2_NOP_IR), .CNT_W(2)
  ) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_pc(in_pc), .in_ir(in_ir), .out_valid(out_valid2), .out_ready(out_ready),
    .out_pc(out_pc2), .out_ir(out_ir2), .flush(flush),
    .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ir);
    in_valid = v;
    in_pc    = pc;
    in_ir    = ir;
  endtask

  // Hard bound on the run in case the clock or a step ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] s_pc [3];
    logic [31:0] s_ir [3];
    s_pc[0] = 32'h3000; s_pc[1] = 32'h3004; s_pc[2] = 32'h3008;
    s_ir[0] = 32'h11;   s_ir[1] = 32'h22;   s_ir[2] = 32'h33;

    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, '0);
    step(); step();
    rst = 1'b0;
    step();

    // Reset, then idle.
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pc",    out_pc, 0);
    check("rst_out_ir",    out_ir, 0);
    check("rst_in_ready",  in_ready, 1);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_flush_cnt", flush_cnt, 0);
    check("rst_d2_out_pc", out_pc2, D2_RESET_PC);
    check("rst_d2_out_ir", out_ir2, D2_NOP_IR);

    // Streaming with out_ready = 1: one cycle of latency, full throughput.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, s_pc[i], s_ir[i]);
      step();
      check($sformatf("stream%0d_valid", i), out_valid, 1);
      check($sformatf("stream%0d_pc", i), out_pc, s_pc[i]);
      check($sformatf("stream%0d_ir", i), out_ir, s_ir[i]);
      check($sformatf("stream%0d_in_ready", i), in_ready, 1);
    end
    drive(1'b0, '0, '0);
    step();
    check("stream_drain_valid", out_valid, 0);
    check("stream_drain_pc", out_pc, 0);
    check("stream_stall_cnt", stall_cnt, 0);

    // Stall: main keeps 0x3000, skid takes 0x3004, 0x3008 waits upstream.
    out_ready = 1'b0;
    drive(1'b1, s_pc[0], s_ir[0]);
    step();
    check("stall_one_pc", out_pc, 32'h3000);
    check("stall_one_in_ready", in_ready, 1);
    drive(1'b1, s_pc[1], s_ir[1]);
    step();                                   // FULL, stall_cnt = 1
    check("stall_full_pc", out_pc, 32'h3000);
    check("stall_full_in_ready", in_ready, 0);
    drive(1'b1, s_pc[2], s_ir[2]);
    step();                                   // stall_cnt = 2
    check("stall_hold_pc", out_pc, 32'h3000);
    check("stall_hold_in_ready", in_ready, 0);
    step();                                   // stall_cnt = 3
    check("stall_cnt_3", stall_cnt, 3);
    out_ready = 1'b1;
    step();                                   // 0x3000 consumed, skid -> main
    check("release0_pc", out_pc, 32'h3004);
    check("release0_ir", out_ir, 32'h22);
    check("release0_in_ready", in_ready, 1);
    step();                                   // 0x3004 consumed, 0x3008 in
    check("release1_pc", out_pc, 32'h3008);
    check("release1_ir", out_ir, 32'h33);
    drive(1'b0, '0, '0);
    step();
    check("release_empty", out_valid, 0);
    check("release_stall_cnt", stall_cnt, 3);
    check("release_flush_cnt", flush_cnt, 0);

    // Flush while FULL with in_valid = 1. in_ready is 0, so only the two held
    // entries are counted. The stall condition still holds in that cycle.
    out_ready = 1'b0;
    drive(1'b1, 32'h4000, 32'h44);
    step();
    drive(1'b1, 32'h4004, 32'h55);
    step();                                   // FULL, stall_cnt = 4
    check("flush_pre_in_ready", in_ready, 0);
    drive(1'b1, 32'h4008, 32'h66);
    flush = 1'b1;
    step();                                   // stall_cnt = 5, flush_cnt = 2
    flush = 1'b0;
    drive(1'b0, '0, '0);
    check("flush_full_valid", out_valid, 0);
    check("flush_full_ir", out_ir, 0);
    check("flush_full_in_ready", in_ready, 1);
    check("flush_full_cnt", flush_cnt, 2);
    check("flush_full_stall_cnt", stall_cnt, 5);
    check("flush_d2_out_ir", out_ir2, D2_NOP_IR);
    check("flush_d2_out_pc", out_pc2, D2_RESET_PC);
    step();
    check("flush_after_valid", out_valid, 0);

    // Flush in ONE with out_fire and an accepted-looking input: the main entry
    // goes downstream (not counted), and the incoming entry is dropped
    // (counted). flush_cnt = 2 + 1.
    out_ready = 1'b1;
    drive(1'b1, 32'h5000, 32'h77);
    step();
    check("flush_one_pre_pc", out_pc, 32'h5000);
    drive(1'b1, 32'h5004, 32'h88);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    check("flush_one_valid", out_valid, 0);
    check("flush_one_cnt", flush_cnt, 3);

    // Saturation: CNT_W = 2 stops at 3, while the 16-bit counter reaches 6.
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 32'h6000, 32'h99);
    step();
    drive(1'b0, '0, '0);
    for (int i = 0; i < 6; i++) step();
    check("sat_d2_stall_cnt", stall_cnt2, 3);
    check("sat_stall_cnt", stall_cnt, 6);
    check("sat_hold_pc", out_pc, 32'h6000);

    // Reset while FULL with flush asserted: reset wins, nothing is counted.
    drive(1'b1, 32'h7000, 32'haa);
    step();
    check("rstfull_pre_in_ready", in_ready, 0);
    rst = 1'b1;
    flush = 1'b1;
    step();
    rst = 1'b0;
    flush = 1'b0;
    drive(1'b0, '0, '0);
    check("rstfull_valid", out_valid, 0);
    check("rstfull_in_ready", in_ready, 1);
    check("rstfull_pc", out_pc, 0);
    check("rstfull_ir", out_ir, 0);
    check("rstfull_stall_cnt", stall_cnt, 0);
    check("rstfull_flush_cnt", flush_cnt, 0);
    step();
    check("rstfull_after_flush_cnt", flush_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
